// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file, write-through bypass, optional zero reg,
// per-register pending scoreboard for long-latency producers.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   raddr_a/b          read addresses
//   rdata_a/b          read data (combinational, bypassed)
//   busy_a/b           pending bit of the read address (bypassed)
//   wen/waddr/wdata    synchronous write; clears the pending bit
//   res_en/res_addr    reserve request; sets the pending bit
//   res_ack            reservation accepted this cycle
//   pend_cnt           registered count of pending registers
//
// Optional debug port, enabled by defining REGFILE_DEBUG_PORT_EN:
//   dbg_addr           debug read address
//   dbg_data           array contents at dbg_addr, no write bypass
//   dbg_pend           full pending vector
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              res_ack,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data,
  output logic [(2**ADDR_W)-1:0] dbg_pend,
`endif
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [ADDR_W:0]   cnt_q;

  logic wz;
  logic rz;
  logic wr_ok;
  logic same;
  logic inc;
  logic clr;
  logic za;
  logic zb;

  // Address 0 is hardwired only when ZERO_REG is set.
  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    wz    = is_zero(waddr);
    rz    = is_zero(res_addr);
    wr_ok = wen && !wz;
    same  = wen && (waddr == res_addr);
  end

  // A pending target may be re-reserved when the
  // same-cycle write retires the old producer.
  always_comb begin
    res_ack = res_en && !rz &&
              (!pend[res_addr] || same);
  end

  // Counter deltas: a re-reserve of a pending reg
  // nets to zero (no inc, no clr).
  always_comb begin
    inc = res_ack && !pend[res_addr];
    clr = wr_ok && pend[waddr] &&
          !(res_ack && (res_addr == waddr));
  end

  always_comb begin
    za = is_zero(raddr_a);
    zb = is_zero(raddr_b);
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    busy_a  = pend[raddr_a];
    if (za) begin
      rdata_a = '0;
      busy_a  = 1'b0;
    end else if (wen && (raddr_a == waddr)) begin
      rdata_a = wdata;
      busy_a  = 1'b0;
    end
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    busy_b  = pend[raddr_b];
    if (zb) begin
      rdata_b = '0;
      busy_b  = 1'b0;
    end else if (wen && (raddr_b == waddr)) begin
      rdata_b = wdata;
      busy_b  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Set after clear so a same-address
  // reservation wins over the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (wr_ok) begin
        pend[waddr] <= 1'b0;
      end
      if (res_ack) begin
        pend[res_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      unique case ({inc, clr})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pend_cnt = cnt_q;

`ifdef REGFILE_DEBUG_PORT_EN
  always_comb begin
    dbg_data = regs[dbg_addr];
    if (is_zero(dbg_addr)) begin
      dbg_data = '0;
    end
  end

  assign dbg_pend = pend;
`endif

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the multi-cycle/pipelined CPU datapath: 2 async read ports, 1 sync write port, write-through bypass, optional hardwired-zero register.
- Adds a per-register pending scoreboard: long-latency producers (loads, MUL/DIV) reserve a destination at issue and clear it on writeback.
- Control logic uses busy flags and the reserve acknowledge to stall on RAW/WAW hazards.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NREGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations, never busy; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- raddr_a  in  ADDR_W  read port A address
- raddr_b  in  ADDR_W  read port B address
- rdata_a  out  DATA_W  read port A data (combinational)
- rdata_b  out  DATA_W  read port B data (combinational)
- busy_a  out  1  pending bit of raddr_a (after same-cycle bypass)
- busy_b  out  1  pending bit of raddr_b (after same-cycle bypass)
- wen  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- res_en  in  1  reserve request for res_addr
- res_addr  in  ADDR_W  register to mark pending
- res_ack  out  1  reservation accepted this cycle (combinational)
- pend_cnt  out  ADDR_W+1  number of currently pending registers (registered)

Behaviour:
- Reset: clk edge with rst=1 clears all registers to 0, all pending bits to 0, pend_cnt to 0. rst overrides wen/res_en in the same cycle. After reset, rdata_a/b = 0, busy_a/b = 0, pend_cnt = 0.
- Write: on clk edge, if wen and not (ZERO_REG && waddr==0), regs[waddr] <= wdata and pend[waddr] <= 0, unless it is re-reserved the same cycle (see below).
- Read, combinational:
  - ZERO_REG && raddr==0 -> data 0, busy 0.
  - Else if wen && raddr==waddr -> data = wdata, busy 0 (write-through bypass).
  - Else data = regs[raddr], busy = pend[raddr].
  - Both ports are independent; same address on both is legal.
- Reserve:
  - res_ack = res_en && !(ZERO_REG && res_addr==0) && (!pend[res_addr] || (wen && waddr==res_addr)).
  - If res_ack, pend[res_addr] <= 1 on the edge.
  - res_en on an already-pending register with no same-cycle clearing write -> res_ack=0, no state change (WAW stall).
  - Reserve on zero register when ZERO_REG=1 -> res_ack=0.
- Simultaneous write and reserve, same address: data written, pend ends at 1 (new reservation wins), pend_cnt unchanged.
- pend_cnt: next = pend_cnt + (res_ack && target not already pending) - (write clears a set bit and is not re-reserved). Never wraps: max NREGS (or NREGS-1 with ZERO_REG).
- Writing a non-pending register is legal; pend stays 0, count unchanged.
- No read latency; write visible to reads in the same cycle via bypass, and from the array on the next cycle.

Optional Feature:
- Macro REGFILE_DEBUG_PORT_EN.
- Defined: adds input dbg_addr [ADDR_W] and outputs dbg_data [DATA_W] and dbg_pend [NREGS] (full pending vector) for the VGA/segment debug display.
  - dbg_data is combinational from the array, with no write bypass.
  - Zero-register rule applies.
- Undefined: these ports do not exist; no extra logic.

Test Plan:
- Reset: write 0xDEADBEEF to r5, reserve r6, assert rst one cycle -> rdata(r5)=0, busy(r6)=0, pend_cnt=0.
- Zero register (ZERO_REG=1): wen, waddr=0, wdata=0x1234 -> rdata_a(r0)=0; res_en r0 -> res_ack=0, pend_cnt=0.
- Bypass: wen r7=0xA5A5A5A5 with raddr_a=raddr_b=7 -> both rdata=0xA5A5A5A5 in the same cycle, busy 0; next cycle identical from the array.
- Scoreboard:
  - reserve r3 -> res_ack=1, next cycle busy_a(r3)=1, pend_cnt=1.
  - reserve r3 again -> res_ack=0, pend_cnt=1.
  - write r3=0x55 -> busy 0, pend_cnt=0.
- Write and re-reserve same cycle: r4 pending, wen r4=0x99 with res_en r4 -> res_ack=1, r4 reads 0x99, busy stays 1, pend_cnt unchanged.
- Parameter sweep DATA_W=16, ADDR_W=3, ZERO_REG=0: reserve all 8 registers -> pend_cnt=8; write r0=0x7 -> rdata(r0)=0x7, pend_cnt=7.
